// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer granting two requesters access to one shared
// combinational ALU: grant in IDLE, ack while the ALU computes, done after capture.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FW    = 4,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [FW-1:0]    funct0,
    input  logic [FW-1:0]    funct1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1,
    output logic             zero0,
    output logic             zero1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_funct,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    output logic             busy,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   sel;
    logic   last;
    logic   grant;
    logic   gsel;

    // Next-state, grant decision and Moore handshake decode
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gsel      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    // On a tie the requester not served last wins
                    gsel      = (req0 && req1) ? ~last : req1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                ack0      = ~sel;
                ack1      = sel;
                state_nxt = RESP;
            end
            RESP: begin
                done0     = ~sel;
                done1     = sel;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_funct <= '0;
            res0      <= '0;
            res1      <= '0;
            zero0     <= 1'b0;
            zero1     <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sel       <= gsel;
                last      <= gsel;
                alu_a     <= gsel ? a1 : a0;
                alu_b     <= gsel ? b1 : b0;
                alu_funct <= gsel ? funct1 : funct0;
            end
            // ALU has had the whole EXEC cycle to settle; capture for the owner only
            if (state == EXEC) begin
                if (sel) begin
                    res1  <= alu_s;
                    zero1 <= alu_z;
                    cnt1  <= cnt1 + CW'(1);
                end else begin
                    res0  <= alu_s;
                    zero0 <= alu_z;
                    cnt0  <= cnt0 + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU answers both DUTs
// (CW=16 and CW=2); expected results are queued per requester and checked on done.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  funct0, funct1;

    logic        ack0, ack1, done0, done1, zero0, zero1, busy, alu_z;
    logic [31:0] res0, res1, alu_a, alu_b, alu_s;
    logic [3:0]  alu_funct;
    logic [15:0] cnt0, cnt1;

    logic        ack0_2, ack1_2, done0_2, done1_2, zero0_2, zero1_2, busy_2, alu_z_2;
    logic [31:0] res0_2, res1_2, alu_a_2, alu_b_2, alu_s_2;
    logic [3:0]  alu_funct_2;
    logic [1:0]  cnt0_2, cnt1_2;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    bit   prev_done = 1'b0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_s   = alu_f(alu_a, alu_b, alu_funct);
    assign alu_z   = (alu_s == 32'd0);
    assign alu_s_2 = alu_f(alu_a_2, alu_b_2, alu_funct_2);
    assign alu_z_2 = (alu_s_2 == 32'd0);

    alu_arbiter #(.WIDTH(32), .FW(4), .CW(16)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .funct0(funct0), .funct1(funct1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1), .zero0(zero0), .zero1(zero1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct),
        .alu_s(alu_s), .alu_z(alu_z), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    alu_arbiter #(.WIDTH(32), .FW(4), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .funct0(funct0), .funct1(funct1),
        .ack0(ack0_2), .ack1(ack1_2), .done0(done0_2), .done1(done1_2),
        .res0(res0_2), .res1(res1_2), .zero0(zero0_2), .zero1(zero1_2),
        .alu_a(alu_a_2), .alu_b(alu_b_2), .alu_funct(alu_funct_2),
        .alu_s(alu_s_2), .alu_z(alu_z_2), .busy(busy_2), .cnt0(cnt0_2), .cnt1(cnt1_2)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pops the owner's queue and checks result, flag and counters
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done0 || done1) begin
                chk_cnt++;
                if (prev_done || (done0 && done1)) begin
                    $display("FAIL done_spacing: done0=%0b done1=%0b prev_done=%0b, required isolated single pulse",
                             done0, done1, prev_done);
                end else pass_cnt++;
            end
            if (done0) begin
                chk_cnt++;
                if (q0.size() == 0) begin
                    $display("FAIL sb_done0: unexpected done0, res0=%h", res0);
                end else begin
                    pass_cnt++;
                    e = q0.pop_front();
                    exp_cnt0++;
                    chk_cnt++;
                    if (res0 !== e.res || zero0 !== e.z) begin
                        $display("FAIL sb_res0: got %h/z%0b, required %h/z%0b", res0, zero0, e.res, e.z);
                    end else pass_cnt++;
                    chk_cnt++;
                    if (cnt0 !== 16'(exp_cnt0) || cnt0_2 !== exp_cnt0[1:0]) begin
                        $display("FAIL sb_cnt0: got %0d/%0d, required %0d/%0d",
                                 cnt0, cnt0_2, 16'(exp_cnt0), exp_cnt0[1:0]);
                    end else pass_cnt++;
                end
            end
            if (done1) begin
                chk_cnt++;
                if (q1.size() == 0) begin
                    $display("FAIL sb_done1: unexpected done1, res1=%h", res1);
                end else begin
                    pass_cnt++;
                    e = q1.pop_front();
                    exp_cnt1++;
                    chk_cnt++;
                    if (res1 !== e.res || zero1 !== e.z) begin
                        $display("FAIL sb_res1: got %h/z%0b, required %h/z%0b", res1, zero1, e.res, e.z);
                    end else pass_cnt++;
                    chk_cnt++;
                    if (cnt1 !== 16'(exp_cnt1) || cnt1_2 !== exp_cnt1[1:0]) begin
                        $display("FAIL sb_cnt1: got %0d/%0d, required %0d/%0d",
                                 cnt1, cnt1_2, 16'(exp_cnt1), exp_cnt1[1:0]);
                    end else pass_cnt++;
                end
            end
            prev_done = done0 | done1;
        end
    end

    task automatic push0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        logic [31:0] r;
        r = alu_f(a, b, f);
        q0.push_back({r, (r == 32'd0)});
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        logic [31:0] r;
        r = alu_f(a, b, f);
        q1.push_back({r, (r == 32'd0)});
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete(); q1.delete();
        exp_cnt0 = 0; exp_cnt1 = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || {ack0, ack1, done0, done1} !== 4'b0) begin
            $display("FAIL reset_ctrl: busy=%0b ack/done=%b, required 0/0000", busy, {ack0, ack1, done0, done1});
        end else pass_cnt++;
        chk_cnt++;
        if (res0 !== 32'd0 || res1 !== 32'd0 || zero0 !== 1'b0 || zero1 !== 1'b0) begin
            $display("FAIL reset_res: res0=%h res1=%h z=%0b%0b, required zeros", res0, res1, zero0, zero1);
        end else pass_cnt++;
        chk_cnt++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_funct !== 4'd0) begin
            $display("FAIL reset_regs: cnt=%0d,%0d alu=%h,%h,%h, required zeros", cnt0, cnt1, alu_a, alu_b, alu_funct);
        end else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; funct0 = 4'd0;
        push0(32'd5, 32'd3, 4'd0);
        @(posedge clk); @(negedge clk);
        chk_cnt++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL single_ack: ack0=%0b ack1=%0b busy=%0b, required 1 0 1", ack0, ack1, busy);
        end else pass_cnt++;
        chk_cnt++;
        if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_funct !== 4'd0) begin
            $display("FAIL single_alu_in: %h %h %h, required 5 3 0", alu_a, alu_b, alu_funct);
        end else pass_cnt++;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (done0 !== 1'b1 || ack0 !== 1'b0 || res0 !== 32'd8 || zero0 !== 1'b0 || cnt0 !== 16'd1 || res1 !== 32'd0) begin
            $display("FAIL single_done: done0=%0b ack0=%0b res0=%0d z0=%0b cnt0=%0d res1=%0d, required 1 0 8 0 1 0",
                     done0, ack0, res0, zero0, cnt0, res1);
        end else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || done0 !== 1'b0) begin
            $display("FAIL single_idle: busy=%0b done0=%0b, required 0 0", busy, done0);
        end else pass_cnt++;
    endtask

    task automatic test_tie();
        int ack0_at = -1;
        int ack1_at = -1;
        do_reset();
        req0 = 1'b1; a0 = 32'd10; b0 = 32'd4; funct0 = 4'd0;
        req1 = 1'b1; a1 = 32'd7;  b1 = 32'd7; funct1 = 4'd1;
        push0(32'd10, 32'd4, 4'd0);
        push1(32'd7, 32'd7, 4'd1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 2) req0 = 1'b0;
            if (i == 5) req1 = 1'b0;
            @(negedge clk);
            if (ack0 && ack0_at < 0) ack0_at = i;
            if (ack1 && ack1_at < 0) ack1_at = i;
        end
        chk_cnt++;
        if (ack0_at !== 1 || ack1_at !== 4) begin
            $display("FAIL tie_order: ack0 at %0d ack1 at %0d, required 1 and 4", ack0_at, ack1_at);
        end else pass_cnt++;
        chk_cnt++;
        if (res1 !== 32'd0 || zero1 !== 1'b1 || res0 !== 32'd14) begin
            $display("FAIL tie_result: res1=%h z1=%0b res0=%0d, required 0 1 14", res1, zero1, res0);
        end else pass_cnt++;
    endtask

    task automatic test_alternate();
        int nack = 0;
        do_reset();
        req0 = 1'b1; a0 = 32'd100; b0 = 32'd1; funct0 = 4'd0;
        req1 = 1'b1; a1 = 32'hF0F0; b1 = 32'h0FF3; funct1 = 4'd2;
        for (int k = 0; k < 6; k++) begin
            push0(32'd100, 32'd1, 4'd0);
            push1(32'hF0F0, 32'h0FF3, 4'd2);
        end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (nack >= 12) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
            if (ack0 || ack1) begin
                chk_cnt++;
                if (ack1 !== ((nack % 2) == 1) || ack0 !== ((nack % 2) == 0)) begin
                    $display("FAIL alt_grant%0d: ack0=%0b ack1=%0b, required requester %0d", nack, ack0, ack1, nack % 2);
                end else pass_cnt++;
                nack++;
            end
        end
        chk_cnt++;
        if (nack !== 12 || cnt0 !== 16'd6 || cnt1 !== 16'd6) begin
            $display("FAIL alt_counts: acks=%0d cnt0=%0d cnt1=%0d, required 12 6 6", nack, cnt0, cnt1);
        end else pass_cnt++;
        chk_cnt++;
        if (q0.size() != 0 || q1.size() != 0) begin
            $display("FAIL alt_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
        end else pass_cnt++;
    endtask

    task automatic test_withdraw();
        bit seen0 = 1'b0;
        int n1 = 0;
        do_reset();
        req1 = 1'b1; a1 = 32'd9; b1 = 32'd2; funct1 = 4'd1;
        push1(32'd9, 32'd2, 4'd1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; funct0 = 4'd0; end
            if (i == 2) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
            if (ack0 || done0) seen0 = 1'b1;
            if (ack1) n1++;
        end
        chk_cnt++;
        if (seen0 !== 1'b0 || n1 !== 1) begin
            $display("FAIL withdraw_hs: req0 handshake seen=%0b ack1 count=%0d, required 0 and 1", seen0, n1);
        end else pass_cnt++;
        chk_cnt++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd1 || res1 !== 32'd7) begin
            $display("FAIL withdraw_state: cnt0=%0d cnt1=%0d res1=%0d, required 0 1 7", cnt0, cnt1, res1);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; funct0 = 4'd0;
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (ack0 !== 1'b1 || alu_a !== 32'd1) begin
            $display("FAIL rstmid_exec: ack0=%0b alu_a=%h, required 1 and 1", ack0, alu_a);
        end else pass_cnt++;
        @(posedge clk); @(negedge clk);
        chk_cnt++;
        if (done0 !== 1'b0 || busy !== 1'b0 || res1 !== 32'd0 || cnt1 !== 16'd0 || cnt0 !== 16'd0) begin
            $display("FAIL rstmid_ctrl: done0=%0b busy=%0b res1=%h cnt=%0d,%0d, required all 0",
                     done0, busy, res1, cnt0, cnt1);
        end else pass_cnt++;
        chk_cnt++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_funct !== 4'd0) begin
            $display("FAIL rstmid_alu: %h %h %h, required zeros", alu_a, alu_b, alu_funct);
        end else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete(); q1.delete();
        exp_cnt0 = 0; exp_cnt1 = 0;
        req0 = 1'b1; a0 = 32'd20; b0 = 32'd22; funct0 = 4'd0;
        push0(32'd20, 32'd22, 4'd0);
        @(posedge clk); @(negedge clk);
        chk_cnt++;
        if (ack0 !== 1'b1 || alu_a !== 32'd20) begin
            $display("FAIL rstmid_regrant: ack0=%0b alu_a=%0d, required 1 20", ack0, alu_a);
        end else pass_cnt++;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (done0 !== 1'b1 || res0 !== 32'd42 || cnt0 !== 16'd1) begin
            $display("FAIL rstmid_done: done0=%0b res0=%0d cnt0=%0d, required 1 42 1", done0, res0, cnt0);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int wrap_seq[5] = '{1, 2, 3, 0, 1};
        int nack = 0;
        int nd = 0;
        do_reset();
        req0 = 1'b1; a0 = 32'd6; b0 = 32'd3; funct0 = 4'd3;
        for (int k = 0; k < 5; k++) push0(32'd6, 32'd3, 4'd3);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (nack >= 5) req0 = 1'b0;
            @(negedge clk);
            if (ack0) nack++;
            if (done0) begin
                chk_cnt++;
                if (nd >= 5) begin
                    $display("FAIL wrap_extra: done0 number %0d, required only 5", nd + 1);
                end else if (cnt0_2 !== 2'(wrap_seq[nd])) begin
                    $display("FAIL wrap_cnt%0d: cnt0(CW=2)=%0d, required %0d", nd, cnt0_2, wrap_seq[nd]);
                end else pass_cnt++;
                nd++;
            end
        end
        chk_cnt++;
        if (nd !== 5 || cnt0 !== 16'd5 || res0 !== 32'd7) begin
            $display("FAIL wrap_total: dones=%0d cnt0=%0d res0=%0d, required 5 5 7", nd, cnt0, res0);
        end else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; funct0 = '0; funct1 = '0;
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_withdraw();
        test_reset_mid();
        test_wrap();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU. Each requester presents operands and a function code with a request/acknowledge handshake. The arbiter grants one requester at a time, drives the registered ALU inputs, captures the ALU result and zero flag, and returns them to the granted requester with a one-cycle done pulse. It sits between the board-level test/control logic and the single `ALU` instance, which is instantiated outside this block.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `FW`, 4, function-code width
- `CW`, 16, per-requester completed-operation counter width

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  request; held high with stable operands until the matching ack
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands per requester
- `funct0`, `funct1`  in  FW  ALU function code per requester
- `ack0`, `ack1`  out  1  one-cycle pulse; operands captured, requester may drop req
- `done0`, `done1`  out  1  one-cycle pulse; result valid
- `res0`, `res1`  out  WIDTH  last result for that requester; held until its next done
- `zero0`, `zero1`  out  1  last ALU zero flag for that requester; held like res
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operands
- `alu_funct`  out  FW  registered ALU function
- `alu_s`  in  WIDTH  ALU result
- `alu_z`  in  1  ALU zero flag
- `busy`  out  1  high in any state other than IDLE
- `cnt0`, `cnt1`  out  CW  completed operations per requester; wraps modulo 2^CW

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE. No other transitions except reset.
- IDLE:
  - If no request is high, stay in IDLE.
  - If exactly one request is high, grant that requester.
  - If both requests are high, grant the requester other than `last` (the last-granted pointer).
  - On grant: load `alu_a`/`alu_b`/`alu_funct` from the granted requester, record `sel`, set `last`=`sel`, go to EXEC.
- EXEC:
  - `ack[sel]`=1.
  - At the end of the cycle, capture `alu_s`→`res[sel]`, `alu_z`→`zero[sel]` and increment `cnt[sel]`. Go to RESP.
- RESP:
  - `done[sel]`=1. Go to IDLE.
- The ALU input registers hold their value outside IDLE-grant edges. `res`/`zero` of the non-selected requester never change.
- A request dropped before it is granted is simply not serviced. No error is flagged.
- A request still high in the IDLE cycle after its own RESP counts as a new request and is serviced again.
- The function code is passed through unmodified. The arbiter does not interpret it.
- Reset values:
  - state=IDLE, `last`=1 (requester 0 wins the first tie).
  - All ack/done=0, `busy`=0.
  - `res0`/`res1`=0, `zero0`/`zero1`=0, `cnt0`/`cnt1`=0.
  - `alu_a`=`alu_b`=0, `alu_funct`=0.
- Reset mid-operation (EXEC or RESP) aborts the operation: no done pulse, no counter increment, all outputs take their reset values on the next cycle.

## Timing
- ack and done are Moore outputs decoded from state and `sel`; they are glitch-free relative to `clk`.
- Request sampled high in IDLE at edge k:
  - ALU inputs valid and `ack` high in cycle k+1.
  - `res`/`zero` updated at edge k+1.
  - `done` high in cycle k+2.
  - IDLE again from edge k+2.
- Fixed latency: done follows ack by exactly one cycle. Sustained throughput is one operation per 3 cycles.
- `busy` rises the cycle after the grant edge and falls the cycle after RESP.
- The ALU path has one full cycle from register `alu_*` to capture.
- Under continuous requests from both requesters, grants strictly alternate 0,1,0,1...

## Test plan
- Single request, bench ALU returns A+B for funct=0: req0 with a0=5, b0=3, funct0=0 → ack0 one cycle later, then done0 with res0=8, zero0=0, cnt0=1; res1 stays 0.
- Simultaneous first requests right after reset: req0 and req1 both high (requester 1 with funct1=1 (A−B), a1=b1=7) → requester 0 is serviced first, then requester 1 with res1=0, zero1=1. Ack order is 0 then 1, spaced 3 cycles apart.
- Both requesters held high for 12 operations → grants alternate, cnt0=cnt1=6, done never asserted two cycles in a row.
- Request withdrawn while the other requester is being serviced → the withdrawn requester receives no ack or done, and its cnt is unchanged.
- `rst` asserted during EXEC → no done pulse; the next cycle shows busy=0, all res/cnt=0, `alu_*`=0; a following req0 is granted normally.
- Counter wrap with CW=2: 5 operations on requester 0 → cnt0 sequence 1,2,3,0,1.
